// File: rtl/project_button_ctrl.sv
// project_button_ctrl: Avalon-MM push-button controller with synchroniser, debounce, sticky edge capture and maskable irq.
// Define BUTTON_RELEASE_EDGE_EN to also capture release edges in EDGE[2*WIDTH-1:WIDTH].
module project_button_ctrl #(
  parameter int unsigned WIDTH          = 3,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd50000,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

`ifdef BUTTON_RELEASE_EDGE_EN
  localparam int unsigned EW = 2 * WIDTH;
`else
  localparam int unsigned EW = WIDTH;
`endif

  logic [WIDTH-1:0] w_pins;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] w_deb_nxt;
  logic [WIDTH-1:0] w_rise;
  logic [15:0]      r_cnt     [WIDTH];
  logic [15:0]      w_cnt_nxt [WIDTH];
  logic [15:0]      r_period;
  logic [15:0]      w_eff;
  logic [EW-1:0]    r_mask;
  logic [EW-1:0]    r_edge;
  logic [EW-1:0]    w_set;
  logic [EW-1:0]    w_clr;
  logic             w_wr;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_pins   = ACTIVE_LOW ? ~in_port : in_port;
  assign w_eff    = (r_period == '0) ? 16'd1 : r_period;
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  // 17-bit compare so c+1 cannot wrap; >= lets a lowered period terminate at once
  always_comb begin
    w_deb_nxt = r_deb;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (({1'b0, r_cnt[i]} + 17'd1) >= {1'b0, w_eff})
          w_deb_nxt[i] = r_sync2[i];
        else
          w_cnt_nxt[i] = r_cnt[i] + 16'd1;
      end
    end
  end

  assign w_rise = w_deb_nxt & ~r_deb;

`ifdef BUTTON_RELEASE_EDGE_EN
  logic [WIDTH-1:0] w_fall;
  assign w_fall = r_deb & ~w_deb_nxt;
  assign w_set  = {w_fall, w_rise};
`else
  assign w_set  = w_rise;
`endif

  assign w_clr = (w_wr && address == 2'd3) ? writedata[EW-1:0] : '0;

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd[WIDTH-1:0] = r_deb;
      2'd1:    w_rd[15:0]      = r_period;
      2'd2:    w_rd[EW-1:0]    = r_mask;
      default: w_rd[EW-1:0]    = r_edge;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_deb    <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_period <= DEFAULT_PERIOD;
      r_mask   <= '0;
      r_edge   <= '0;
      readdata <= '0;
    end else begin
      r_sync1  <= w_pins;
      r_sync2  <= r_sync1;
      r_deb    <= w_deb_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_edge   <= (r_edge & ~w_clr) | w_set;
      if (w_wr && address == 2'd1) r_period <= writedata[15:0];
      if (w_wr && address == 2'd2) r_mask   <= writedata[EW-1:0];
      readdata <= w_rd;
    end
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_project_button_ctrl.sv
// Self-checking bench for project_button_ctrl: read expectations are queued when a read is issued and compared once readdata is produced.
`timescale 1ns/1ps
module tb_project_button_ctrl;

`ifdef BUTTON_RELEASE_EDGE_EN
  localparam int          EW  = 6;
  localparam bit          REL = 1'b1;
`else
  localparam int          EW  = 3;
  localparam bit          REL = 1'b0;
`endif
  localparam logic [31:0] EMASK = (32'd1 << EW) - 32'd1;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [31:0] readdata;
  logic [2:0]  in_port    = 3'b111;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t         sb[$];
  logic [31:0] got_q[$];

  project_button_ctrl #(
    .WIDTH(3),
    .DEFAULT_PERIOD(16'd50000),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // All tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic issue_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    address = a;
    @(negedge clk);
    got_q.push_back(readdata);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    sb_t e; logic [31:0] g;
    issue_read(2'd1, 32'h0000C350, "rst_period");
    issue_read(2'd0, 32'h0, "rst_data");
    issue_read(2'd2, 32'h0, "rst_mask");
    issue_read(2'd3, 32'h0, "rst_edge");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: irq=%b expected 0", irq); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_registers;
    sb_t e; logic [31:0] g;
    bus_write(2'd1, 32'hABCD_1234);
    issue_read(2'd1, 32'h0000_1234, "period_width");
    bus_write(2'd2, 32'hFFFF_FFFF);
    issue_read(2'd2, EMASK, "mask_width");
    bus_write(2'd0, 32'hFFFF_FFFF);
    issue_read(2'd0, 32'h0, "data_ro");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_no_edge_irq: irq=%b expected 0", irq); end
    bus_write(2'd2, 32'h0);
    issue_read(2'd2, 32'h0, "mask_clear");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_press;
    sb_t e; logic [31:0] g;
    bus_write(2'd1, 32'd4);
    in_port[0] = 1'b0;
    for (int k = 1; k <= 8; k++)
      issue_read(2'd0, (k >= 7) ? 32'h1 : 32'h0, $sformatf("press_lat_k%0d", k));
    issue_read(2'd3, 32'h1, "press_edge");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked: irq=%b expected 0", irq); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_glitch;
    sb_t e; logic [31:0] g;
    in_port[1] = 1'b0;
    idle(3);
    in_port[1] = 1'b1;
    for (int k = 1; k <= 8; k++) issue_read(2'd0, 32'h1, "glitch_data");
    issue_read(2'd3, 32'h1, "glitch_edge");
    in_port[1] = 1'b0;
    idle(10);
    issue_read(2'd0, 32'h3, "hold_data");
    issue_read(2'd3, 32'h3, "hold_edge");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_irq;
    sb_t e; logic [31:0] g;
    bus_write(2'd2, 32'h3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_masked_on: irq=%b expected 1", irq); end
    bus_write(2'd3, 32'h1);
    issue_read(2'd3, 32'h2, "clear_bit0");
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_still_on: irq=%b expected 1", irq); end
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear: irq=%b expected 0", irq); end
    issue_read(2'd3, 32'h0, "clear_bit1");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_back_to_back_set_clear;
    sb_t e; logic [31:0] g;
    in_port[2] = 1'b0;
    idle(5);
    bus_write(2'd3, 32'h4);
    issue_read(2'd3, 32'h4, "set_wins");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL set_wins_irq: irq=%b expected 0", irq); end
    bus_write(2'd3, 32'h4);
    issue_read(2'd3, 32'h0, "later_clear");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_period;
    sb_t e; logic [31:0] g;
    in_port = 3'b111;
    idle(10);
    issue_read(2'd0, 32'h0, "all_released");
    issue_read(2'd3, REL ? 32'h38 : 32'h0, "release_edges");
    bus_write(2'd3, 32'hFFFF_FFFF);
    issue_read(2'd3, 32'h0, "edge_cleared");
    bus_write(2'd1, 32'd0);
    issue_read(2'd1, 32'h0, "period_zero");
    in_port[0] = 1'b0;
    for (int k = 1; k <= 5; k++)
      issue_read(2'd0, (k >= 4) ? 32'h1 : 32'h0, $sformatf("p0_lat_k%0d", k));
    bus_write(2'd1, 32'd1000);
    issue_read(2'd1, 32'd1000, "period_1000");
    in_port[0] = 1'b1;
    idle(500);
    bus_write(2'd1, 32'd10);
    issue_read(2'd0, 32'h1, "lower_before");
    issue_read(2'd0, 32'h0, "lower_after");
    bus_write(2'd3, 32'hFFFF_FFFF);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_press_release;
    sb_t e; logic [31:0] g;
    bus_write(2'd1, 32'd2);
    in_port[0] = 1'b0;
    idle(6);
    in_port[0] = 1'b1;
    idle(6);
    issue_read(2'd3, REL ? 32'h09 : 32'h01, "press_release_edge");
    issue_read(2'd0, 32'h0, "press_release_data");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  task automatic test_reset_mid;
    sb_t e; logic [31:0] g;
    bus_write(2'd2, 32'hFFFF_FFFF);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: irq=%b expected 1", irq); end
    bus_write(2'd1, 32'd8);
    in_port[1] = 1'b0;
    idle(4);
    issue_read(2'd1, 32'd8, "pre_reset_period");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL async_readdata: readdata=%h expected 0", readdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: irq=%b expected 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    idle(12);
    issue_read(2'd3, 32'h0, "post_reset_edge");
    issue_read(2'd0, 32'h0, "post_reset_data");
    issue_read(2'd1, 32'h0000C350, "post_reset_period");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", e.name, g, e.exp); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset;
    test_registers;
    test_press;
    test_glitch;
    test_irq;
    test_back_to_back_set_clear;
    test_period;
    test_press_release;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/project_button_ctrl.md
Name: project_button_ctrl

Overview:
- Avalon-MM slave controller for the board push-buttons, sitting between the raw button pins and the Nios II data bus.
- Per-button functions: synchronise, debounce with a software-programmable period, capture press events into sticky edge bits, and raise a maskable interrupt.
- Supersedes the bare read-only input port for button reads.

Parameters:
- WIDTH, 3, number of buttons.
- DEFAULT_PERIOD, 16'd50000, debounce period in clk cycles loaded at reset (1 ms at 50 MHz).
- ACTIVE_LOW, 1, 1 = pins read 0 when pressed; the core inverts so internal 1 = pressed.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  registered read data
- in_port  input  WIDTH  raw button pins, asynchronous
- irq  output  1  interrupt request, active-high, level

Behaviour:
- Reset: all of the following are asynchronous on reset_n low.
  - Synchronisers, debounced state, counters, edge capture, irq mask and readdata clear to 0.
  - Period register loads DEFAULT_PERIOD.
  - The debounced state resets to "released" regardless of the pins.
- Register map (word addresses):
  - 0 DATA (RO): debounced state in bits [WIDTH-1:0].
  - 1 PERIOD (RW): bits [15:0].
  - 2 IRQMASK (RW): bits [WIDTH-1:0].
  - 3 EDGE (RW1C): bits [WIDTH-1:0].
  - Unused bits read 0; writes to DATA are ignored.
- Read: readdata updates every clk to the mux of address; latency is 1 cycle. chipselect is not required for reads; reads have no side effects.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0.
- Synchroniser: 2 flops per bit, after optional inversion.
- Debounce (per bit, independent):
  - s = synchronised sample, d = debounced state, c = 16-bit counter.
  - If s==d: c<=0.
  - Else if c+1 >= eff_period: d<=s, c<=0.
  - Else: c<=c+1.
  - eff_period = PERIOD, or 1 when PERIOD==0.
  - d changes on the edge at which s has differed from d for eff_period consecutive cycles. Total pin-to-DATA-register latency is 2+eff_period cycles; DATA becomes visible on readdata one cycle later.
  - A glitch shorter than eff_period resets c and leaves d unchanged.
  - Writing PERIOD mid-count applies immediately; the >= comparison ensures a lowered period terminates at once.
- Edge capture:
  - EDGE[i] is set on the same edge where d[i] goes 0->1 (press).
  - A write of 1 to bit i clears EDGE[i]; a write of 0 has no effect.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Bits are sticky until cleared.
- irq = |(EDGE & IRQMASK), combinational from the registers, so it follows a mask or clear in the cycle after the write edge.
- Reset mid-debounce: the count is discarded and no edge is produced.

Optional Feature:
- Macro: BUTTON_RELEASE_EDGE_EN.
- Defined:
  - EDGE is widened to 2*WIDTH bits. Bits [WIDTH-1:0] capture press (0->1) and bits [2*WIDTH-1:WIDTH] capture release (1->0).
  - IRQMASK is also 2*WIDTH bits, and irq ORs all masked bits.
  - Same RW1C and set-wins rules apply to the release bits.
- Undefined:
  - Only press capture exists.
  - Bits [31:WIDTH] of EDGE and IRQMASK read 0 and ignore writes.

Test Plan:
- Reset check: release reset with in_port=3'b111 (all released), PERIOD=default. Read address 1 -> 32'h0000C350; read addresses 0, 2, 3 -> 0; irq=0.
- Press and debounce: write PERIOD=4; drive in_port[0]=0 steadily. DATA[0]=1 exactly 6 cycles after the pin change; EDGE=3'b001; irq stays 0 while IRQMASK=0.
- Glitch rejection: with PERIOD=4, pulse in_port[1] low for 3 cycles. DATA and EDGE unchanged. Then hold it low for 10 cycles -> EDGE[1]=1.
- Interrupt and clear: IRQMASK=3'b011 with EDGE=3'b011 -> irq=1. Write EDGE=3'b001 -> EDGE=3'b010, irq=1. Write 3'b010 -> irq=0 one cycle after the write edge.
- Simultaneous set and clear: time a write of EDGE=3'b100 to the exact cycle where button 2's debounce completes -> EDGE[2] reads 1.
- Period edge cases: write PERIOD=0 -> each press registers 3 cycles after the pin change. With PERIOD=1000 and c≈500, write PERIOD=10 -> d updates on the next cycle. With BUTTON_RELEASE_EDGE_EN defined, a press then release of button 0 sets EDGE=6'b001001.
